// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants and helpers for the BCD modulus counter.
// Decade width and integer-to-BCD conversion, reused by every counter instance.
package bcd_mod_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 4;
  localparam int BCD_MAX_W  = DIGIT_W * MAX_DIGITS;

  localparam logic [BCD_MAX_W-1:0] ZERO_BCD = '0;

  // Packs value into MAX_DIGITS decades, least significant decade in bits [3:0].
  function automatic logic [BCD_MAX_W-1:0] to_bcd(input int value);
    logic [BCD_MAX_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// One BCD decade: load, forced wrap value, or single-step up/down with carry/borrow out.
// The parent decides when the whole counter wraps at its modulus.
module bcd_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] d,
  input  logic               step,
  input  logic               up,
  input  logic               wrap,
  input  logic [DIGIT_W-1:0] wrap_val,
  output logic [DIGIT_W-1:0] q,
  output logic               ci,
  output logic               bi
);

  assign ci = step & up & (q == 4'd9);
  assign bi = step & ~up & (q == 4'd0);

  // Modulus wrap overrides the natural decimal step so every decade lands together.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (wrap) begin
      q <= wrap_val;
    end else if (step) begin
      if (up) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-decade BCD up/down counter with programmable modulus, validated parallel load
// and en-gated carry/borrow for chaining into the next stage.
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Co,
  output logic                  Bo,
  output logic                  err
);

  localparam int W = DIGIT_W * DIGITS;
  localparam logic [BCD_MAX_W-1:0] MAX_FULL = to_bcd(MODULUS - 1);
  localparam logic [W-1:0] MAX_BCD  = MAX_FULL[W-1:0];
  localparam logic [W-1:0] ZERO_W   = ZERO_BCD[W-1:0];

  logic              digits_ok;
  logic              load_ok;
  logic              count;
  logic              at_max;
  logic              at_zero;
  logic              wrap;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] ci;
  logic [DIGITS-1:0] bi;
  logic              unused_top_chain;

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (D[DIGIT_W*i +: DIGIT_W] > 4'd9) digits_ok = 1'b0;
    end
  end

  // With every decade valid, raw vector ordering matches decimal ordering.
  assign load_ok = digits_ok & (D <= MAX_BCD);

  assign count   = en & ~load;
  assign at_max  = (Q == MAX_BCD);
  assign at_zero = (Q == ZERO_W);
  assign wrap    = count & (up ? at_max : at_zero);

  assign Co = en & up & at_max;
  assign Bo = en & ~up & at_zero;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign step[i] = count;
    end else begin : g_upper
      assign step[i] = ci[i-1] | bi[i-1];
    end

    bcd_digit u_digit (
      .clk      (clk),
      .clrn     (clrn),
      .ld       (load & load_ok),
      .d        (D[DIGIT_W*i +: DIGIT_W]),
      .step     (step[i]),
      .up       (up),
      .wrap     (wrap),
      .wrap_val (up ? 4'd0 : MAX_BCD[DIGIT_W*i +: DIGIT_W]),
      .q        (Q[DIGIT_W*i +: DIGIT_W]),
      .ci       (ci[i]),
      .bi       (bi[i])
    );
  end

  // The most significant decade never needs to propagate further: wrap catches it first.
  assign unused_top_chain = ci[DIGITS-1] | bi[DIGITS-1];

  always_ff @(posedge clk) begin
    if (!clrn) err <= 1'b0;
    else       err <= load & ~load_ok;
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: seconds->minutes chain (modulus 60) plus an hours counter (24),
// directed scenarios then random traffic against an integer-valued reference model.
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       clrn;
  logic       load_s, load_m, load_h;
  logic [7:0] d_s, d_m, d_h;
  logic       en_s, en_h;
  logic       up, up_h;
  logic [7:0] q_s, q_m, q_h;
  logic       co_s, bo_s, co_m, bo_m, co_h, bo_h;
  logic       err_s, err_m, err_h;

  int n_chk  = 0;
  int n_pass = 0;

  int sv, mv, hv;
  bit es, em, eh;

  always #5 clk = ~clk;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (
    .clk(clk), .clrn(clrn), .load(load_s), .D(d_s), .en(en_s), .up(up),
    .Q(q_s), .Co(co_s), .Bo(bo_s), .err(err_s));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (
    .clk(clk), .clrn(clrn), .load(load_m), .D(d_m), .en(co_s), .up(up),
    .Q(q_m), .Co(co_m), .Bo(bo_m), .err(err_m));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk(clk), .clrn(clrn), .load(load_h), .D(d_h), .en(en_h), .up(up_h),
    .Q(q_h), .Co(co_h), .Bo(bo_h), .err(err_h));

  function automatic int dec(input logic [7:0] d);
    return int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [7:0] tobcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit legal(input logic [7:0] d, input int m);
    return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9) && (dec(d) < m);
  endfunction

  task automatic upd(inout int v, inout bit e, input int m, input bit ld,
                     input logic [7:0] d, input bit en, input bit u);
    if (!clrn) begin
      v = 0; e = 1'b0;
    end else if (ld) begin
      if (legal(d, m)) begin v = dec(d); e = 1'b0; end
      else e = 1'b1;
    end else begin
      e = 1'b0;
      if (en) v = u ? (v + 1) % m : (v + m - 1) % m;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: check combinational carry/borrow before the edge, state after it.
  task automatic step();
    bit cs, bs, em_en, cm, bm, ch, bh;
    cs    = en_s & up & (sv == 59);
    bs    = en_s & ~up & (sv == 0);
    em_en = cs;
    cm    = em_en & up & (mv == 59);
    bm    = em_en & ~up & (mv == 0);
    ch    = en_h & up_h & (hv == 23);
    bh    = en_h & ~up_h & (hv == 0);
    #2;
    check("sec_co", 8'(co_s), 8'(cs));
    check("sec_bo", 8'(bo_s), 8'(bs));
    check("min_co", 8'(co_m), 8'(cm));
    check("min_bo", 8'(bo_m), 8'(bm));
    check("hr_co",  8'(co_h), 8'(ch));
    check("hr_bo",  8'(bo_h), 8'(bh));
    @(posedge clk);
    upd(sv, es, 60, load_s, d_s, en_s, up);
    upd(mv, em, 60, load_m, d_m, em_en, up);
    upd(hv, eh, 24, load_h, d_h, en_h, up_h);
    #1;
    check("sec_q",   q_s, tobcd(sv));
    check("min_q",   q_m, tobcd(mv));
    check("hr_q",    q_h, tobcd(hv));
    check("sec_err", 8'(err_s), 8'(es));
    check("min_err", 8'(err_m), 8'(em));
    check("hr_err",  8'(err_h), 8'(eh));
  endtask

  task automatic idle();
    clrn = 1'b1;
    load_s = 1'b0; load_m = 1'b0; load_h = 1'b0;
    en_s = 1'b0; en_h = 1'b0;
    up = 1'b1; up_h = 1'b1;
  endtask

  initial begin
    sv = 0; mv = 0; hv = 0; es = 0; em = 0; eh = 0;
    d_s = 8'h00; d_m = 8'h00; d_h = 8'h00;
    idle();
    clrn = 1'b0;
    @(posedge clk); #1;

    // Reset beats load and enable
    clrn = 1'b0; load_s = 1'b1; d_s = 8'h45; en_s = 1'b1;
    load_h = 1'b1; d_h = 8'h12; en_h = 1'b1;
    step();
    check("reset_q", q_s, 8'h00);
    idle();

    // Up wrap at 59 with carry
    load_s = 1'b1; d_s = 8'h58; step();
    load_s = 1'b0; en_s = 1'b1; up = 1'b1; step();
    check("up_59", q_s, 8'h59);
    #2 check("co_at_59", 8'(co_s), 8'h01);
    step();
    check("up_wrap", q_s, 8'h00);
    en_s = 1'b0; #1 check("co_after", 8'(co_s), 8'h00);
    load_s = 1'b1; d_s = 8'h09; step();
    load_s = 1'b0; en_s = 1'b1; step();
    check("digit_carry", q_s, 8'h10);
    idle();

    // Down wrap on the hours counter
    load_h = 1'b1; d_h = 8'h00; step();
    load_h = 1'b0; en_h = 1'b1; up_h = 1'b0;
    #1 check("bo_at_0", 8'(bo_h), 8'h01);
    step();
    check("down_wrap", q_h, 8'h23);
    load_h = 1'b1; d_h = 8'h20; en_h = 1'b0; step();
    load_h = 1'b0; en_h = 1'b1; step();
    check("digit_borrow", q_h, 8'h19);
    idle();

    // Illegal loads hold Q and pulse err
    load_s = 1'b1; d_s = 8'h60; step();
    check("ill_60_err", 8'(err_s), 8'h01);
    check("ill_60_q", q_s, 8'h10);
    load_s = 1'b0; step();
    check("err_clear", 8'(err_s), 8'h00);
    load_s = 1'b1; d_s = 8'h3A; step();
    check("ill_3a_err", 8'(err_s), 8'h01);
    d_s = 8'h37; step();
    check("legal_37", q_s, 8'h37);
    check("legal_err", 8'(err_s), 8'h00);

    // Load wins over enable, then hold
    load_s = 1'b1; d_s = 8'h12; en_s = 1'b1; up = 1'b1; step();
    check("load_over_en", q_s, 8'h12);
    load_s = 1'b0; en_s = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("hold", q_s, 8'h12);

    // Cascade 59:59 -> 00:00 on one edge
    load_s = 1'b1; d_s = 8'h59; load_m = 1'b1; d_m = 8'h59; step();
    load_s = 1'b0; load_m = 1'b0; en_s = 1'b1; up = 1'b1;
    #1 check("chain_co", 8'(co_m), 8'h01);
    step();
    check("chain_min", q_m, 8'h00);
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      clrn   = ($urandom_range(0, 24) != 0);
      load_s = ($urandom_range(0, 5) == 0);
      load_m = ($urandom_range(0, 9) == 0);
      load_h = ($urandom_range(0, 5) == 0);
      d_s = $urandom_range(0, 1) ? tobcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
      d_m = $urandom_range(0, 1) ? tobcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
      d_h = $urandom_range(0, 1) ? tobcd($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
      en_s = ($urandom_range(0, 3) != 0);
      en_h = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 3) != 0);
      up_h = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD up/down counter with programmable modulus, synchronous load and cascade carry/borrow.
- Successor to the single-decade counter in the clock datapath.
- One instance covers seconds/minutes (MODULUS=60) or hours (MODULUS=24, 12).
- Instances chain via Co/Bo into the next stage's en.

Parameters:
- DIGITS, 2, number of BCD decades; legal 1..4.
- MODULUS, 60, count range 0..MODULUS-1 (decimal integer); legal 2..10**DIGITS.

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  synchronous active-low reset
- load  input  1  synchronous parallel load request
- D  input  4*DIGITS  BCD load value, digit 0 in D[3:0]
- en  input  1  count enable (cascade input)
- up  input  1  direction: 1 = increment, 0 = decrement
- Q  output  4*DIGITS  BCD count, digit 0 in Q[3:0]
- Co  output  1  carry: en & up & (Q == MODULUS-1), combinational
- Bo  output  1  borrow: en & ~up & (Q == 0), combinational
- err  output  1  registered one-cycle pulse: rejected load

Behaviour:
- Interface: one clock clk; reset clrn is synchronous and active-low. All state changes occur on the rising edge of clk only.
- Reset: clrn=0 at an edge gives Q=0 and err=0. clrn has top priority over load and en. Reset mid-count or mid-load wins unconditionally.
- Priority after reset: load > en. When load=1, en and up are ignored that cycle.
- Load validation:
  - D is legal only if every digit is <= 9 and value(D) <= MODULUS-1.
  - Legal D: Q <= D next edge, err <= 0.
  - Illegal D: Q holds, err <= 1 for exactly one cycle. err returns to 0 on the next edge unless another illegal load occurs.
- Counting (load=0, en=1):
  - up=1: Q == MODULUS-1 wraps to 0; otherwise Q+1 in BCD. A digit at 9 wraps to 0 and carries into the next digit.
  - up=0: Q == 0 wraps to MODULUS-1 (BCD); otherwise Q-1 in BCD. A digit at 0 becomes 9 and borrows from the next digit.
- en=0 with load=0: Q holds. err is 0 whenever no illegal load occurred on the previous edge.
- Co/Bo are gated by en. This lets a chain advance the next stage in the same cycle this stage wraps. Co and Bo are never both 1.
- Direction change takes effect on the same edge up is sampled. No pipeline; latency from input to Q is one clock.
- Q never holds a non-BCD digit or a value >= MODULUS in any reachable state.

Decomposition:
- Shared package:
  - Function converting an integer to a 4*DIGITS BCD vector.
  - Localparams MAX_BCD (MODULUS-1 in BCD) and ZERO_BCD.
  - BCD digit width constant (4).
- Sub-module bcd_digit, one per decade via generate:
  - Inputs: clk, clrn, ld, d, step, up, wrap_val.
  - Outputs: q, plus ci/bi chained to the next digit.
  - The top level computes the modulus-wrap condition and forces every digit to its wrap value on wrap.

Test Plan:
- Reset/priority: clrn=0 with load=1, D=8'h45, en=1 -> Q=8'h00, err=0 next edge.
- Up wrap (MODULUS=60): load 8'h58, then en=1, up=1 for 2 cycles -> Q=8'h59 with Co=1, then Q=8'h00 with Co=0. Digit carry check: 8'h09 -> 8'h10.
- Down wrap (MODULUS=24): load 8'h00, en=1, up=0 -> Bo=1 that cycle, next Q=8'h23. Then 8'h20 -> 8'h19.
- Illegal load: D=8'h60 (MODULUS=60) or D=8'h3A -> Q unchanged, err=1 for one cycle then 0. Legal D=8'h37 -> Q=8'h37, err=0.
- Load vs enable: load=1, en=1, up=1, D=8'h12 -> Q=8'h12, not 8'h13. Then en=0 for 5 cycles -> Q holds 8'h12, Co=Bo=0.
- Cascade: seconds (60) Co -> minutes (60) en; start 8'h59/8'h59, one up cycle -> both stages 8'h00 on the same edge, minutes Co=1 before that edge.
